// File: rtl/seg_scan_if.sv
// Bus-side content interface for the 4-digit SEG scan controller.
// The master drives display content and the strobe; the slave drives the pins.
interface seg_scan_if;
  logic [15:0] disp_data;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [3:0]  bright;
  logic        data_vld;
  logic [3:0]  seg_sel;
  logic [7:0]  seg_led;
  logic        frame_done;

  modport master (
    output disp_data, dp, digit_en, bright, data_vld,
    input  seg_sel, seg_led, frame_done
  );

  modport slave (
    input  disp_data, dp, digit_en, bright, data_vld,
    output seg_sel, seg_led, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with ghost blanking, PWM dimming
// and frame-boundary double buffering. Optional macro: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned DIGIT_CYC = 32,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int unsigned SLOT_CYC = DIGIT_CYC / 16;
  localparam int unsigned MAX_CYC  = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
  localparam int unsigned CNT_W    = $clog2(MAX_CYC);
  localparam int unsigned SUB_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  bright;
  } cfg_t;

  localparam cfg_t CFG_RST = '{data: 16'h0000, dp: 4'h0, en: 4'hF, bright: 4'hF};

  // Active-high g..a glyphs for one hex nibble.
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [3:0]       slot_q, slot_d;
  cfg_t             staging_q, staging_d;
  cfg_t             shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [3:0]       seg_sel_q, seg_sel_d;
  logic [7:0]       seg_led_q, seg_led_d;
  logic             frame_done_q, frame_done_d;

  logic [3:0]       lz_mask;
  logic [3:0]       en_eff;
  logic [3:0]       nib;
  logic             lit;

  // Sequencing, staging capture and frame-boundary shadow load.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    slot_d    = slot_q;
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    // First BLANK cycle of digit 0: a strobe in the previous cycle is already in staging.
    if ((state_q == ST_BLANK) && (idx_q == 2'd0) && (cnt_q == '0) && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end

    if (bus.data_vld) begin
      staging_d = '{data: bus.disp_data, dp: bus.dp, en: bus.digit_en, bright: bus.bright};
      pending_d = 1'b1;
    end

    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
          state_d = ST_ON;
          cnt_d   = '0;
          sub_d   = '0;
          slot_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == CNT_W'(DIGIT_CYC - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (sub_q == SUB_W'(SLOT_CYC - 1)) begin
            sub_d  = '0;
            slot_d = slot_q + 4'd1;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end
    endcase
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and everything above it is 0 with no dp lit.
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = (shadow_d.data[15:12] == 4'h0) && !shadow_d.dp[3];
    lz_mask[2] = (shadow_d.data[15:8]  == 8'h00) && !shadow_d.dp[2];
    lz_mask[1] = (shadow_d.data[15:4]  == 12'h000) && !shadow_d.dp[1];
  end
`else
  always_comb begin
    lz_mask = 4'b0000;
  end
`endif

  // Outputs are decoded from next state so the registered pins line up with the state.
  always_comb begin
    en_eff       = shadow_d.en & ~lz_mask;
    nib          = shadow_d.data[{idx_d, 2'b00} +: 4];
    lit          = (state_d == ST_ON) && en_eff[idx_d] && (slot_d <= shadow_d.bright);
    seg_sel_d    = 4'hF;
    seg_led_d    = 8'hFF;
    if (lit) begin
      seg_sel_d = ~(4'b0001 << idx_d);
      seg_led_d = ~{shadow_d.dp[idx_d], hex7seg(nib)};
    end
    frame_done_d = (state_d == ST_ON) && (idx_d == 2'd3) && (cnt_d == CNT_W'(DIGIT_CYC - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      sub_q        <= '0;
      slot_q       <= 4'd0;
      staging_q    <= CFG_RST;
      shadow_q     <= CFG_RST;
      pending_q    <= 1'b0;
      seg_sel_q    <= 4'hF;
      seg_led_q    <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
      slot_q       <= slot_d;
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_sel_q    <= seg_sel_d;
      seg_led_q    <= seg_led_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg_sel    = seg_sel_q;
  assign bus.seg_led    = seg_led_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues expected pin states at chosen
// cycles, a negedge monitor pops and compares them.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGIT_CYC = 32;
  localparam int unsigned BLANK_CYC = 2;
  localparam int SLOT    = DIGIT_CYC / 16;
  localparam int DIG_LEN = BLANK_CYC + DIGIT_CYC;
  localparam int FRAME   = 4 * DIG_LEN;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  bright;
  } cfg_t;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [7:0] led;
    logic       fd;
  } exp_t;

  localparam cfg_t DEF    = '{data: 16'h0000, dp: 4'h0, en: 4'hF, bright: 4'hF};
  localparam cfg_t CFG_A  = '{data: 16'h12AF, dp: 4'h0, en: 4'hF, bright: 4'hF};
  localparam cfg_t CFG_B  = '{data: 16'h12AF, dp: 4'h0, en: 4'hF, bright: 4'h7};
  localparam cfg_t CFG_C  = '{data: 16'h4321, dp: 4'h1, en: 4'h5, bright: 4'hF};
  localparam cfg_t CFG_D1 = '{data: 16'h1111, dp: 4'h0, en: 4'hF, bright: 4'h0};
  localparam cfg_t CFG_D2 = '{data: 16'h2222, dp: 4'h0, en: 4'hF, bright: 4'h0};
  localparam cfg_t CFG_E  = '{data: 16'h0050, dp: 4'h0, en: 4'hF, bright: 4'hF};
  localparam cfg_t CFG_X  = '{data: 16'hBEEF, dp: 4'hF, en: 4'hF, bright: 4'h3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_ctrl #(
    .DIGIT_CYC (DIGIT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc;
  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  // Cycle 0 is the first cycle with rst low.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Active-low segment images, dp off.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  function automatic exp_t model(input int c, input cfg_t cf);
    exp_t       e;
    int         p = c % FRAME;
    int         d = p / DIG_LEN;
    int         q = p % DIG_LEN;
    logic [3:0] en = cf.en;
    logic [3:0] nib;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (cf.data[15:12] == 4'h0 && !cf.dp[3]) en[3] = 1'b0;
    if (cf.data[15:8] == 8'h00 && !cf.dp[2]) en[2] = 1'b0;
    if (cf.data[15:4] == 12'h000 && !cf.dp[1]) en[1] = 1'b0;
`endif
    e.cyc = c;
    e.sel = 4'hF;
    e.led = 8'hFF;
    e.fd  = (p == FRAME - 1);
    if (q >= BLANK_CYC && en[d] && ((q - BLANK_CYC) / SLOT) <= int'(cf.bright)) begin
      e.sel[d] = 1'b0;
      nib      = cf.data[d*4 +: 4];
      e.led    = glyph(nib);
      e.led[7] = ~cf.dp[d];
    end
    return e;
  endfunction

  // Checkpoints per digit: blank edges, first ON slots, bright=7 edge, window end.
  task automatic push_frame(input int f, input cfg_t cf);
    int qs[10] = '{0, 1, 2, 3, 4, 5, 17, 18, 32, 33};
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 10; k++)
        sb_q.push_back(model(f * FRAME + d * DIG_LEN + qs[k], cf));
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 10 * FRAME) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != t) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, t);
    end
  endtask

  // One-cycle strobe in cycle t; inputs are scrambled afterwards to prove capture.
  task automatic strobe(input int t, input cfg_t cf);
    wait_cyc(t);
    bus.disp_data = cf.data;
    bus.dp        = cf.dp;
    bus.digit_en  = cf.en;
    bus.bright    = cf.bright;
    bus.data_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.data_vld  = 1'b0;
    bus.disp_data = ~cf.data;
    bus.dp        = ~cf.dp;
    bus.digit_en  = ~cf.en;
    bus.bright    = ~cf.bright;
  endtask

  always @(negedge clk) begin
    if (!rst && sb_q.size() > 0) begin
      if (sb_q[0].cyc < cyc) begin
        mon_e = sb_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed checkpoint: cycle %0d passed (now %0d)", mon_e.cyc, cyc);
      end else if (sb_q[0].cyc == cyc) begin
        mon_e = sb_q.pop_front();
        vectors++;
        if (bus.seg_sel !== mon_e.sel || bus.seg_led !== mon_e.led ||
            bus.frame_done !== mon_e.fd) begin
          miscompares++;
          $display("FAIL pins @cyc %0d: sel=%h led=%h fd=%b, expected sel=%h led=%h fd=%b",
                   cyc, bus.seg_sel, bus.seg_led, bus.frame_done,
                   mon_e.sel, mon_e.led, mon_e.fd);
        end
      end
    end
  end

  initial begin
    int n;
    bus.data_vld  = 1'b0;
    bus.disp_data = 16'hDEAD;
    bus.dp        = 4'hA;
    bus.digit_en  = 4'h3;
    bus.bright    = 4'h1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_frame(0, DEF);
    push_frame(1, CFG_A);
    rst = 1'b0;

    strobe(50, CFG_A);
    push_frame(2, CFG_B);
    strobe(FRAME + 60, CFG_B);
    push_frame(3, CFG_C);
    strobe(2 * FRAME + 60, CFG_C);
    push_frame(4, CFG_D2);
    strobe(3 * FRAME + 30, CFG_D1);
    strobe(4 * FRAME - 1, CFG_D2);
    push_frame(5, CFG_E);
    strobe(4 * FRAME + 60, CFG_E);

    // Pending content is dropped by a mid-frame reset.
    strobe(6 * FRAME + 40, CFG_X);
    wait_cyc(6 * FRAME + 70);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_frame(0, DEF);
    push_frame(1, DEF);
    @(posedge clk);
    #1;
    rst = 1'b0;

    n = 0;
    while (sb_q.size() > 0 && n < 4 * FRAME) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d checkpoints never reached", sb_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit, 8-segment display on the AHB-Lite SEG peripheral.
- Takes a 16-bit hex value plus per-digit enable/decimal-point and a global brightness setting; sequences digit select and segment drive with inter-digit ghost blanking and PWM dimming.
- Bus-side logic presents new content with a one-cycle strobe. The block double-buffers it so a frame never mixes old and new data.

Parameters:
- DIGIT_CYC, 32, clock cycles of the ON window per digit; must be a multiple of 16 and at least 16.
- BLANK_CYC, 2, clock cycles of all-off blanking before each digit's ON window; must be at least 1.

Ports:
- clk  input  1  system clock (HCLK domain).
- rst  input  1  synchronous, active-high reset.
- disp_data  input  16  four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- dp  input  4  decimal point per digit, 1 = lit.
- digit_en  input  4  per-digit enable, 1 = shown.
- bright  input  4  duty level, 0..15; lit for (bright+1)/16 of the ON window.
- data_vld  input  1  one-cycle strobe; captures disp_data/dp/digit_en/bright into staging.
- seg_sel  output  4  digit select, active-low one-cold; bit i = digit i.
- seg_led  output  8  segments, active-low; [6:0] = g..a, [7] = dp.
- frame_done  output  1  one-cycle pulse at end of each frame.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values: seg_sel = 4'hF, seg_led = 8'hFF, frame_done = 0.
- Reset clears staging, shadow, pending and all counters, and forces the FSM to BLANK with digit index 0.
- Staging/shadow contents after reset: disp_data 0, dp 0, digit_en 4'hF, bright 15.
- FSM states: BLANK and ON, with a 2-bit digit index idx (0→1→2→3→0).
- BLANK lasts BLANK_CYC cycles. Outputs: seg_sel = 4'hF, seg_led = 8'hFF.
- ON lasts DIGIT_CYC cycles. The window is divided into 16 slots of DIGIT_CYC/16 cycles each.
  - Digit idx is driven during slots 0..bright: seg_sel = ~(1<<idx), seg_led = ~{dp[idx], hex7seg(nibble idx)}.
  - Remaining slots drive the BLANK values.
  - If digit_en[idx] = 0, the whole ON window drives BLANK values. Timing is unchanged, so frame rate stays constant.
- Timeline after rst deasserts, with cycle 0 the first cycle rst = 0:
  - Cycles 0..BLANK_CYC-1: blank.
  - Digit 0 lit starting at cycle BLANK_CYC.
  - Frame length = 4*(BLANK_CYC+DIGIT_CYC) cycles.
- frame_done is high in exactly the last cycle of digit 3's ON window.
- Hex decode: standard 0-9 and A,b,C,d,E,F glyphs.
- Buffering:
  - data_vld writes staging and sets pending.
  - On the cycle after frame_done (the first BLANK cycle of digit 0), if pending, shadow ← staging and pending clears.
  - Display always reads shadow.
- Boundary conditions:
  - data_vld coincident with the frame_done cycle is included in the shadow load at the immediately following boundary.
  - Multiple data_vld strobes within a frame: last one wins.
  - data_vld never stalls scanning.
  - rst mid-frame restarts the full sequence at BLANK, idx 0. Pending data is lost.
  - bright = 15: lit for the full ON window. bright = 0: lit for slot 0 only; never fully dark unless digit disabled.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- When defined: a shadow digit i (i = 3, 2, 1) is treated as disabled if its nibble and all higher nibbles are 0 and its dp bit is 0. Digit 0 is never suppressed, so value 0 shows "0".
- When undefined: all enabled digits are displayed, including leading zeros.
- Timing is identical in both builds.

Test Plan (DIGIT_CYC=32, BLANK_CYC=2, frame 136 cycles, slot 2 cycles):
- Reset held, then released → seg_sel=F, seg_led=FF for cycles 0-1. Cycle 2: seg_sel=E, seg_led=C0 ("0"). frame_done high at cycle 135 only.
- data_vld with disp_data=16'h12AF, bright=15, mid-frame → current frame unchanged. Next frame: digit0 seg_led=8E (F), digit1 88 (A), digit2 A4 (2), digit3 F9 (1).
- bright=7 → each digit lit 16 cycles, then 16 cycles dark (seg_sel=F) within its 32-cycle ON window.
- digit_en=4'b0101, dp=4'b0001 → digits 1 and 3 never selected, frame still 136 cycles. Digit0 seg_led bit7=0.
- Two data_vld strobes (h1111, then h2222) in one frame, second on the frame_done cycle → next frame shows 2222; 1111 never displayed.
- With SEG_LEADING_ZERO_BLANK_EN, disp_data=16'h0050 → digits 3,2 dark; digit1 shows "5", digit0 shows "0". Without the macro → "0050".
